// File: rtl/up_pkg.sv
// Shared types for the 4-bit accumulator CPU sequencer: opcodes, ALU ops,
// sequencer states and the datapath strobe bundle.
package up_pkg;

  typedef enum logic [3:0] {
    OP_JC   = 4'h0, OP_JNC  = 4'h1, OP_CMPI = 4'h2, OP_CMPM = 4'h3,
    OP_LIT  = 4'h4, OP_IN   = 4'h5, OP_LD   = 4'h6, OP_ST   = 4'h7,
    OP_JZ   = 4'h8, OP_JNZ  = 4'h9, OP_ADDI = 4'hA, OP_ADDM = 4'hB,
    OP_JMP  = 4'hC, OP_OUT  = 4'hD, OP_NORI = 4'hE, OP_NORM = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {ALU_PASS = 2'b00, ALU_ADD = 2'b01, ALU_NOR = 2'b10, ALU_CMP = 2'b11} alu_op_e;

  typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC, S_WAIT} seq_state_e;

  typedef struct packed {
    logic    pc_inc;
    logic    pc_load;
    logic    ld_accu;
    logic    ld_flags;
    alu_op_e alu_op;
    logic    sel_imm;
    logic    ram_oe;
    logic    ram_we;
    logic    in_oe;
    logic    out_we;
  } strobe_t;

  function automatic logic is_mem_op(input opcode_e op);
    return (op == OP_CMPM) || (op == OP_LD) || (op == OP_ST) ||
           (op == OP_ADDM) || (op == OP_NORM);
  endfunction

  function automatic logic is_two_byte(input opcode_e op);
    return is_mem_op(op) || (op == OP_JC) || (op == OP_JNC) ||
           (op == OP_JZ) || (op == OP_JNZ) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/up_decode.sv
// Combinational decode of state + latched opcode + flags into datapath strobes.
// Memory ops keep their bus strobes through WAIT but only commit on mem_ready.
module up_decode
  import up_pkg::*;
(
  input  seq_state_e state_i,
  input  opcode_e    instr_i,
  input  logic       c_flag_i,
  input  logic       z_flag_i,
  input  logic       mem_ready_i,
  output strobe_t    strb_o
);

  logic taken;

  always_comb begin
    taken = 1'b0;
    case (instr_i)
      OP_JC:   taken = c_flag_i;
      OP_JNC:  taken = !c_flag_i;
      OP_JZ:   taken = z_flag_i;
      OP_JNZ:  taken = !z_flag_i;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    strb_o = '0;
    case (state_i)
      S_FETCH: strb_o.pc_inc = 1'b1;
      S_EXEC, S_WAIT: begin
        case (instr_i)
          OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: begin
            strb_o.pc_load = taken;
            strb_o.pc_inc  = !taken;
          end
          OP_CMPI: begin strb_o.ld_flags = 1'b1; strb_o.alu_op = ALU_CMP; strb_o.sel_imm = 1'b1; end
          OP_LIT:  begin strb_o.ld_accu = 1'b1; strb_o.alu_op = ALU_PASS; strb_o.sel_imm = 1'b1; end
          OP_IN:   begin strb_o.in_oe = 1'b1; strb_o.ld_accu = 1'b1; end
          OP_OUT:  strb_o.out_we = 1'b1;
          OP_ADDI: begin strb_o.ld_accu = 1'b1; strb_o.ld_flags = 1'b1; strb_o.alu_op = ALU_ADD; strb_o.sel_imm = 1'b1; end
          OP_NORI: begin strb_o.ld_accu = 1'b1; strb_o.ld_flags = 1'b1; strb_o.alu_op = ALU_NOR; strb_o.sel_imm = 1'b1; end
          OP_CMPM: begin strb_o.ram_oe = 1'b1; strb_o.ld_flags = 1'b1; strb_o.alu_op = ALU_CMP; end
          OP_LD:   begin strb_o.ram_oe = 1'b1; strb_o.ld_accu = 1'b1; strb_o.alu_op = ALU_PASS; end
          OP_ST:   strb_o.ram_we = 1'b1;
          OP_ADDM: begin strb_o.ram_oe = 1'b1; strb_o.ld_accu = 1'b1; strb_o.ld_flags = 1'b1; strb_o.alu_op = ALU_ADD; end
          OP_NORM: begin strb_o.ram_oe = 1'b1; strb_o.ld_accu = 1'b1; strb_o.ld_flags = 1'b1; strb_o.alu_op = ALU_NOR; end
          default: ;
        endcase
        // Register loads and the operand-byte skip wait for the RAM handshake
        if (is_mem_op(instr_i)) begin
          strb_o.pc_inc   = mem_ready_i;
          strb_o.ld_accu  = strb_o.ld_accu  && mem_ready_i;
          strb_o.ld_flags = strb_o.ld_flags && mem_ready_i;
        end else if (!is_two_byte(instr_i)) begin
          strb_o.pc_inc = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/up_control_sequencer.sv
// Fetch/execute sequencer for the 4-bit accumulator CPU: run/step control,
// RAM wait states with timeout, and a retired-instruction counter.
module up_control_sequencer
  import up_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [7:0]       program_byte,
  input  logic             c_flag,
  input  logic             z_flag,
  input  logic             mem_ready,
  output logic             phase,
  output logic [3:0]       instr,
  output logic [3:0]       operand,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             ld_accu,
  output logic             ld_flags,
  output logic [1:0]       alu_op,
  output logic             sel_imm,
  output logic             ram_oe,
  output logic             ram_we,
  output logic             in_oe,
  output logic             out_we,
  output logic             halted,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] TIMEOUT = 8'(WAIT_TIMEOUT);

  seq_state_e       state_q, state_d;
  logic             step_mode_q, step_mode_d;
  logic             bus_err_q, bus_err_d;
  logic [3:0]       instr_q, instr_d, operand_q, operand_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d, wait_nxt;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mem_pending;
  strobe_t          strb;

  assign mem_pending = is_mem_op(opcode_e'(instr_q)) && !mem_ready;
  // Low-ready cycles are counted from the first EXEC cycle of the access
  assign wait_nxt    = (state_q == S_EXEC) ? 8'd1 : wait_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    bus_err_d   = bus_err_q;
    instr_d     = instr_q;
    operand_d   = operand_q;
    wait_cnt_d  = wait_cnt_q;
    retired_d   = retired_q;
    case (state_q)
      S_HALT: begin
        if (!bus_err_q) begin
          if (run) begin
            state_d = S_FETCH;
          end else if (step) begin
            state_d     = S_FETCH;
            step_mode_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        instr_d   = program_byte[7:4];
        operand_d = program_byte[3:0];
        state_d   = S_EXEC;
      end
      S_EXEC, S_WAIT: begin
        if (mem_pending) begin
          if (wait_nxt >= TIMEOUT) begin
            state_d     = S_HALT;
            bus_err_d   = 1'b1;
            step_mode_d = 1'b0;
            wait_cnt_d  = '0;
          end else begin
            state_d    = S_WAIT;
            wait_cnt_d = wait_nxt;
          end
        end else begin
          retired_d   = retired_q + CNT_W'(1);
          step_mode_d = 1'b0;
          wait_cnt_d  = '0;
          state_d     = (run && !step_mode_q) ? S_FETCH : S_HALT;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_HALT;
      step_mode_q <= 1'b0;
      bus_err_q   <= 1'b0;
      instr_q     <= '0;
      operand_q   <= '0;
      wait_cnt_q  <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      bus_err_q   <= bus_err_d;
      instr_q     <= instr_d;
      operand_q   <= operand_d;
      wait_cnt_q  <= wait_cnt_d;
      retired_q   <= retired_d;
    end
  end

  up_decode u_decode (
    .state_i    (state_q),
    .instr_i    (opcode_e'(instr_q)),
    .c_flag_i   (c_flag),
    .z_flag_i   (z_flag),
    .mem_ready_i(mem_ready),
    .strb_o     (strb)
  );

  assign phase     = (state_q == S_EXEC) || (state_q == S_WAIT);
  assign halted    = (state_q == S_HALT);
  assign instr     = instr_q;
  assign operand   = operand_q;
  assign bus_error = bus_err_q;
  assign retired   = retired_q;
  assign pc_inc    = strb.pc_inc;
  assign pc_load   = strb.pc_load;
  assign ld_accu   = strb.ld_accu;
  assign ld_flags  = strb.ld_flags;
  assign alu_op    = strb.alu_op;
  assign sel_imm   = strb.sel_imm;
  assign ram_oe    = strb.ram_oe;
  assign ram_we    = strb.ram_we;
  assign in_oe     = strb.in_oe;
  assign out_we    = strb.out_we;

endmodule

// File: tb/tb_up_control_sequencer.sv
// Bench for up_control_sequencer: directed opcode table, hand-written wait /
// timeout / step / reset sequences, and random programs vs an instruction-level model.
module tb_up_control_sequencer;

  localparam int WT = 15;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset, run, step, c_flag, z_flag, mem_ready;
  logic [7:0] program_byte;
  logic phase, pc_inc, pc_load, ld_accu, ld_flags, sel_imm, ram_oe, ram_we, in_oe, out_we, halted, bus_error;
  logic [3:0] instr, operand;
  logic [1:0] alu_op;
  logic [CW-1:0] retired;

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_ret;
  logic exp_berr, exp_halted;
  logic [7:0] exp_byte;

  // {phase, halted, pc_inc, pc_load, ld_accu, ld_flags, alu_op[1:0], sel_imm, ram_oe, ram_we, in_oe, out_we}
  typedef logic [12:0] obs_t;
  localparam obs_t E_HALT  = 13'b0_1_0_0_0_0_00_0_0_0_0_0;
  localparam obs_t E_FETCH = 13'b0_0_1_0_0_0_00_0_0_0_0_0;

  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] b2;
    logic       c;
    logic       z;
    obs_t       exp;
  } vec_t;

  obs_t dut_obs;
  assign dut_obs = {phase, halted, pc_inc, pc_load, ld_accu, ld_flags, alu_op, sel_imm, ram_oe, ram_we, in_oe, out_we};

  always #5 clk = ~clk;

  up_control_sequencer #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .program_byte(program_byte),
    .c_flag(c_flag), .z_flag(z_flag), .mem_ready(mem_ready),
    .phase(phase), .instr(instr), .operand(operand), .pc_inc(pc_inc), .pc_load(pc_load),
    .ld_accu(ld_accu), .ld_flags(ld_flags), .alu_op(alu_op), .sel_imm(sel_imm),
    .ram_oe(ram_oe), .ram_we(ram_we), .in_oe(in_oe), .out_we(out_we),
    .halted(halted), .bus_error(bus_error), .retired(retired)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Opcode -> {ld_accu, ld_flags, alu_op, sel_imm, ram_oe, ram_we, in_oe, out_we} while active
  function automatic logic [8:0] op_strobes(input logic [3:0] op);
    case (op)
      4'h2: return 9'b0_1_11_1_0_0_0_0;
      4'h3: return 9'b0_1_11_0_1_0_0_0;
      4'h4: return 9'b1_0_00_1_0_0_0_0;
      4'h5: return 9'b1_0_00_0_0_0_1_0;
      4'h6: return 9'b1_0_00_0_1_0_0_0;
      4'h7: return 9'b0_0_00_0_0_1_0_0;
      4'hA: return 9'b1_1_01_1_0_0_0_0;
      4'hB: return 9'b1_1_01_0_1_0_0_0;
      4'hD: return 9'b0_0_00_0_0_0_0_1;
      4'hE: return 9'b1_1_10_1_0_0_0_0;
      4'hF: return 9'b1_1_10_0_1_0_0_0;
      default: return 9'b0;
    endcase
  endfunction

  function automatic bit is_mem(input logic [3:0] op);
    return op == 4'h3 || op == 4'h6 || op == 4'h7 || op == 4'hB || op == 4'hF;
  endfunction

  function automatic bit is_jmp(input logic [3:0] op);
    return op == 4'h0 || op == 4'h1 || op == 4'h8 || op == 4'h9 || op == 4'hC;
  endfunction

  function automatic obs_t exp_exec(input logic [3:0] op, input logic c, input logic z, input logic rdy);
    logic [8:0] s;
    logic pi, pl, tk;
    s = op_strobes(op);
    pi = 1'b0;
    pl = 1'b0;
    if (is_mem(op)) begin
      pi = rdy;
      if (!rdy) s[8:7] = 2'b00;
    end else if (is_jmp(op)) begin
      case (op)
        4'h0: tk = c;
        4'h1: tk = !c;
        4'h8: tk = z;
        4'h9: tk = !z;
        default: tk = 1'b1;
      endcase
      pl = tk;
      pi = !tk;
    end
    return {1'b1, 1'b0, pi, pl, s};
  endfunction

  task automatic cyc(input string nm, input obs_t e);
    @(negedge clk);
    chk({nm, ".strobes"}, 32'(dut_obs), 32'(e));
    chk({nm, ".retired"}, 32'(retired), 32'(exp_ret));
    chk({nm, ".bus_error"}, 32'(bus_error), 32'(exp_berr));
    chk({nm, ".instr_operand"}, 32'({instr, operand}), 32'(exp_byte));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_misc();
    c_flag    = 1'($urandom);
    z_flag    = 1'($urandom);
    mem_ready = 1'($urandom);
  endtask

  // One instruction at transaction level: optional HALT cycle, FETCH, then EXEC/WAIT
  // with k low-ready cycles for memory ops.
  task automatic run_instr(input logic [7:0] b1, input logic [7:0] b2, input int k,
                           input bit stepm, input bit run_end);
    logic [3:0] op;
    logic rdy;
    op = b1[7:4];
    if (exp_halted) begin
      run  = !stepm;
      step = stepm ? 1'b1 : 1'($urandom);
      program_byte = 8'($urandom);
      rand_misc();
      cyc("halt", E_HALT);
    end
    run  = !stepm;
    step = 1'($urandom);
    program_byte = b1;
    rand_misc();
    cyc("fetch", E_FETCH);
    exp_byte     = b1;
    program_byte = b2;
    for (int i = 0; i < 64; i++) begin
      c_flag = 1'($urandom);
      z_flag = 1'($urandom);
      step   = 1'($urandom);
      rdy    = is_mem(op) ? (i >= k) : 1'($urandom);
      mem_ready = rdy;
      if (!is_mem(op) || rdy) begin
        run = run_end;
        cyc("exec", exp_exec(op, c_flag, z_flag, rdy));
        exp_ret++;
        exp_halted = stepm || !run_end;
        break;
      end
      run = !stepm;
      cyc("wait", exp_exec(op, c_flag, z_flag, 1'b0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[18];
    bit cur_s, nxt_s, run_end;
    logic [7:0] b1, b2;
    int k;

    vecs[0]  = '{8'h49, 8'h00, 1'b0, 1'b0, 13'b1_0_0_0_1_0_00_1_0_0_0_0};
    vecs[1]  = '{8'h00, 8'h13, 1'b1, 1'b0, 13'b1_0_0_1_0_0_00_0_0_0_0_0};
    vecs[2]  = '{8'h00, 8'h13, 1'b0, 1'b0, 13'b1_0_1_0_0_0_00_0_0_0_0_0};
    vecs[3]  = '{8'h15, 8'h27, 1'b0, 1'b1, 13'b1_0_0_1_0_0_00_0_0_0_0_0};
    vecs[4]  = '{8'h15, 8'h27, 1'b1, 1'b0, 13'b1_0_1_0_0_0_00_0_0_0_0_0};
    vecs[5]  = '{8'h80, 8'h42, 1'b0, 1'b1, 13'b1_0_0_1_0_0_00_0_0_0_0_0};
    vecs[6]  = '{8'h9F, 8'h00, 1'b1, 1'b1, 13'b1_0_1_0_0_0_00_0_0_0_0_0};
    vecs[7]  = '{8'hC3, 8'h21, 1'b0, 1'b0, 13'b1_0_0_1_0_0_00_0_0_0_0_0};
    vecs[8]  = '{8'h27, 8'h00, 1'b0, 1'b0, 13'b1_0_0_0_0_1_11_1_0_0_0_0};
    vecs[9]  = '{8'h50, 8'h00, 1'b0, 1'b0, 13'b1_0_0_0_1_0_00_0_0_0_1_0};
    vecs[10] = '{8'hD0, 8'h00, 1'b0, 1'b0, 13'b1_0_0_0_0_0_00_0_0_0_0_1};
    vecs[11] = '{8'hA3, 8'h00, 1'b0, 1'b0, 13'b1_0_0_0_1_1_01_1_0_0_0_0};
    vecs[12] = '{8'hE5, 8'h00, 1'b0, 1'b0, 13'b1_0_0_0_1_1_10_1_0_0_0_0};
    vecs[13] = '{8'h60, 8'h05, 1'b0, 1'b0, 13'b1_0_1_0_1_0_00_0_1_0_0_0};
    vecs[14] = '{8'h7A, 8'h3C, 1'b0, 1'b0, 13'b1_0_1_0_0_0_00_0_0_1_0_0};
    vecs[15] = '{8'hBE, 8'h01, 1'b0, 1'b0, 13'b1_0_1_0_1_1_01_0_1_0_0_0};
    vecs[16] = '{8'hF2, 8'h44, 1'b0, 1'b0, 13'b1_0_1_0_1_1_10_0_1_0_0_0};
    vecs[17] = '{8'h3C, 8'h0A, 1'b0, 1'b0, 13'b1_0_1_0_0_1_11_0_1_0_0_0};

    reset = 1'b0; run = 1'b0; step = 1'b0; program_byte = 8'h00;
    c_flag = 1'b0; z_flag = 1'b0; mem_ready = 1'b0;
    exp_ret = '0; exp_berr = 1'b0; exp_byte = 8'h00; exp_halted = 1'b1;
    #1;
    cyc("reset", E_HALT);
    reset = 1'b1;

    // Directed opcode table: each entry runs HALT -> FETCH -> EXEC -> HALT
    for (int i = 0; i < 18; i++) begin
      run = 1'b1; step = 1'b0; mem_ready = 1'b1;
      c_flag = vecs[i].c; z_flag = vecs[i].z;
      program_byte = vecs[i].b1;
      cyc($sformatf("vec%0d.halt", i), E_HALT);
      cyc($sformatf("vec%0d.fetch", i), E_FETCH);
      exp_byte = vecs[i].b1;
      program_byte = vecs[i].b2;
      run = 1'b0;
      cyc($sformatf("vec%0d.exec", i), vecs[i].exp);
      exp_ret++;
    end
    exp_halted = 1'b1;

    // Wait states: three low cycles, then the longest wait that still completes
    run_instr(8'h60, 8'h05, 3, 1'b0, 1'b0);
    run_instr(8'h7C, 8'h11, WT - 1, 1'b0, 1'b0);

    // Single-step two instructions, then confirm it stays halted
    run_instr(8'hA3, 8'h00, 0, 1'b1, 1'b0);
    run_instr(8'h2B, 8'h00, 0, 1'b1, 1'b0);
    run = 1'b0; step = 1'b0;
    cyc("idle", E_HALT);

    // Random programs mixing free-running and stepped instructions
    cur_s = 1'b0;
    for (int n = 0; n < 300; n++) begin
      nxt_s = ($urandom_range(0, 3) == 0);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      k  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, WT - 1)) : int'($urandom_range(0, 3));
      run_end = cur_s ? 1'b0 : (!nxt_s && ($urandom_range(0, 7) != 0));
      if (n == 299) run_end = 1'b0;
      run_instr(b1, b2, k, cur_s, run_end);
      cur_s = nxt_s;
    end

    // Timeout: ST never acknowledged -> bus_error, stuck in HALT
    run = 1'b1; step = 1'b0; mem_ready = 1'b0; program_byte = 8'h75;
    cyc("to.halt", E_HALT);
    cyc("to.fetch", E_FETCH);
    exp_byte = 8'h75;
    program_byte = 8'h09;
    for (int i = 0; i < WT; i++) cyc("to.wait", 13'b1_0_0_0_0_0_00_0_0_1_0_0);
    exp_berr = 1'b1;
    for (int i = 0; i < 3; i++) cyc("to.stuck", E_HALT);

    // Reset clears the error; then reset asserted mid-EXEC of NORI
    reset = 1'b0;
    exp_berr = 1'b0; exp_ret = '0; exp_byte = 8'h00;
    cyc("clr", E_HALT);
    reset = 1'b1;
    run = 1'b1; mem_ready = 1'b1; program_byte = 8'hE5;
    cyc("nori.halt", E_HALT);
    cyc("nori.fetch", E_FETCH);
    #2;
    chk("nori.exec", 32'(dut_obs), 32'(13'b1_0_0_0_1_1_10_1_0_0_0_0));
    reset = 1'b0;
    #1;
    chk("rst_mid.strobes", 32'(dut_obs), 32'(E_HALT));
    chk("rst_mid.instr", 32'({instr, operand}), 32'h0);
    chk("rst_mid.retired", 32'(retired), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    program_byte = 8'h49;
    cyc("resume.halt", E_HALT);
    cyc("resume.fetch", E_FETCH);
    exp_byte = 8'h49;
    run = 1'b1;
    cyc("resume.exec", 13'b1_0_0_0_1_0_00_1_0_0_0_0);
    exp_ret++;
    cyc("resume.fetch2", E_FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
